mmio_uart_tx: RTL and testbench

//  Memory-mapped console transmitter on the core's data-memory bus, beside RAM in SoC.
//  An address decode in SoC drives sel when ram_addr falls in the UART window.

---
 rtl/soc_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the UART window, STATUS bit positions and FSM states.
package soc_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Registers are word aligned; the two low address bits never matter.
  function automatic logic reg_hit(input logic [3:0] a, input logic [3:0] off);
    logic [1:0] a_word;
    logic [1:0] off_word;
    a_word   = a[3:2];
    off_word = off[3:2];
    return a_word == off_word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output. A push while full
// is still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter: register decode, sticky overflow
// flag, bit-period divisor and the serialiser that drains the TX FIFO.
module mmio_uart_tx
  import soc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        r,
  input  logic [3:0]  w,
  input  logic [3:0]  addr,
  input  logic [31:0] in,
  output logic [31:0] out,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t      state;
  uart_state_t      state_nx;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] timer;
  logic [7:0]       shift;
  logic [7:0]       fifo_dout;
  logic [2:0]       bit_idx;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             push;
  logic             push_acc;
  logic             pop;
  logic             bit_end;
  logic             bit_start;
  logic             tx_nx;
  logic             busy_nx;
  logic             hit_data;
  logic             hit_status;
  logic             hit_div;

  assign hit_data   = sel && reg_hit(addr, UART_TXDATA);
  assign hit_status = sel && reg_hit(addr, UART_STATUS);
  assign hit_div    = sel && reg_hit(addr, UART_DIV);
  assign push       = hit_data && w[0];
  assign push_acc   = push && (!full || pop);
  assign div_eff    = (div == '0) ? DIV_W'(1) : div;
  assign bit_end    = (timer == '0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Zero-latency read mux; the bus sees state from before the current edge.
  always_comb begin
    out = '0;
    if (sel && r) begin
      if (reg_hit(addr, UART_STATUS)) begin
        out[ST_FULL]                   = full;
        out[ST_EMPTY]                  = empty;
        out[ST_BUSY]                   = busy;
        out[ST_OVF]                    = ovf;
        out[ST_COUNT_LSB +: 8]         = 8'(count);
      end else if (reg_hit(addr, UART_DIV)) begin
        out[DIV_W-1:0] = div;
      end
    end
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push && !push_acc) begin
      ovf <= 1'b1;
    end else if (hit_status && w[0] && in[3]) begin
      ovf <= 1'b0;
    end
  end

  // Divisor register with per-byte-lane write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= DIV_W'(DIV_RESET);
    end else if (hit_div) begin
      for (int i = 0; i < DIV_W; i++) begin
        if (w[i/8]) div[i] <= in[i];
      end
    end
  end

  // Serialiser next state: decides when a bit ends, what tx shows next and when to pop.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    tx_nx     = tx;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          state_nx = START;
          tx_nx    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          tx_nx    = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            tx_nx = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
    bit_start = pop || ((state != IDLE) && bit_end && (state_nx != IDLE));
    busy_nx   = (state_nx != IDLE) || push_acc || (count != CW'(pop));
  end

  // Serialiser control registers; the timer reloads from DIV at every bit start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_nx;
      tx    <= tx_nx;
      busy  <= busy_nx;
      if (bit_start)         timer <= div_eff - 1'b1;
      else if (!bit_end)     timer <= timer - 1'b1;
      if (pop)                           bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
    end
  end

  // Shift register holds the byte in flight; bit 0 is the bit on the line.
  always_ff @(posedge clk) begin
    if (pop)                           shift <= fifo_dout;
    else if (state == DATA && bit_end) shift <= {1'b0, shift[7:1]};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, hand-written corner
// sequences, and randomized rounds checked by an idealised UART receiver.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        r = 1'b0;
  logic [3:0]  w = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] in = 32'h0;
  logic [31:0] out;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes [16];

  mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16), .DIV_RESET(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .r     (r),
    .w     (w),
    .addr  (addr),
    .in    (in),
    .out   (out),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic        s;
    logic        rd;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  lanes;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] lanes, input logic s);
    @(negedge clk);
    sel = s; r = 1'b0; w = lanes; addr = a; in = d;
    @(posedge clk);
    #1;
    sel = 1'b0; w = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic s, input logic rd,
                          output logic [31:0] data);
    @(negedge clk);
    sel = s; r = rd; w = 4'h0; addr = a;
    #1;
    data = out;
    sel = 1'b0; r = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) bus_write(4'h0, {24'h0, exp_bytes[i]}, 4'h1, 1'b1);
  endtask

  // Ideal receiver: every cycle of every bit must show the 8N1 level, frames back to back.
  task automatic rx_frames(input int div, input int n);
    int waited = 0;
    bit first = 1'b1;
    while (tx !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("rx_start", {31'h0, tx}, 32'h0);
    if (tx !== 1'b0) return;
    for (int f = 0; f < n; f++) begin
      logic [9:0] frame_exp;
      logic [9:0] frame_obs;
      logic       bad;
      frame_exp = {1'b1, exp_bytes[f], 1'b0};
      frame_obs = '0;
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < div; c++) begin
          if (!first) @(negedge clk);
          first = 1'b0;
          if (c == 0) frame_obs[k] = tx;
          else if (tx !== frame_obs[k]) bad = 1'b1;
        end
      end
      check("rx_frame", {21'h0, bad, frame_obs}, {22'h0, frame_exp});
    end
    @(negedge clk);
    check("rx_end_busy", {31'h0, busy}, 32'h0);
    check("rx_end_tx", {31'h0, tx}, 32'h1);
  endtask

  initial begin
    vec_t        vecs [12];
    logic [31:0] rdata;
    int          div;
    int          n;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'h4, 32'h0,        4'h0, 32'h0000_0002};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h8, 32'h0,        4'h0, 32'h0000_0010};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,        4'h0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'hC, 32'h0,        4'h0, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h8, 32'hFFFF_1234, 4'h1, 32'h0000_0034};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'hA, 32'h0000_AB00, 4'h2, 32'h0000_AB34};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0041, 4'hF, 32'h0000_0002};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'hC, 32'h0000_0007, 4'hF, 32'h0000_AB34};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h8, 32'h0,        4'h0, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h4, 32'h0,        4'h0, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'h8, 32'h0000_0099, 4'h3, 32'h0000_AB34};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'h8, 32'h0000_0004, 4'h3, 32'h0000_0004};

    #12;
    check("reset_tx_held", {31'h0, tx}, 32'h1);
    check("reset_busy_held", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register vectors: a write is followed by a readback of the register it implies.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].a, vecs[i].d, vecs[i].lanes, vecs[i].s);
        if (i == 6)      bus_read(4'h4, 1'b1, 1'b1, rdata);
        else             bus_read(4'h8, 1'b1, 1'b1, rdata);
      end else begin
        bus_read(vecs[i].a, vecs[i].s, vecs[i].rd, rdata);
      end
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    // Single byte 0x55 at DIV=4.
    exp_bytes[0] = 8'h55;
    fork
      begin
        push_bytes(1);
        check("busy_after_push", {31'h0, busy}, 32'h1);
      end
      rx_frames(4, 1);
    join

    // Back-to-back frames with no idle gap.
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h3C;
    fork
      push_bytes(2);
      rx_frames(4, 2);
    join

    // Overflow: one byte in flight, eight queued, the tenth dropped.
    bus_write(4'h8, 32'd100, 4'h3, 1'b1);
    for (int i = 0; i < 10; i++) exp_bytes[i] = 8'(i + 1);
    push_bytes(10);
    bus_read(4'h4, 1'b1, 1'b1, rdata);
    check("ovf_status", rdata, 32'h0000_080D);
    bus_write(4'h4, 32'h0000_0008, 4'h1, 1'b1);
    bus_read(4'h4, 1'b1, 1'b1, rdata);
    check("ovf_cleared", rdata, 32'h0000_0805);
    pulse_reset();
    bus_read(4'h4, 1'b1, 1'b1, rdata);
    check("flush_status", rdata, 32'h0000_0002);
    bus_read(4'h8, 1'b1, 1'b1, rdata);
    check("div_reset", rdata, 32'h0000_0010);

    // Reset while data bit 3 (a zero) is on the line.
    bus_write(4'h8, 32'd4, 4'h3, 1'b1);
    bus_write(4'h0, 32'h0000_00F7, 4'h1, 1'b1);
    repeat (18) @(negedge clk);
    check("mid_data_bit3", {31'h0, tx}, 32'h0);
    pulse_reset();
    bus_read(4'h4, 1'b1, 1'b1, rdata);
    check("post_reset_status", rdata, 32'h0000_0002);
    begin
      logic stray = 1'b0;
      repeat (60) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) stray = 1'b1;
      end
      check("no_residual_frame", {31'h0, stray}, 32'h0);
    end

    // DIV=0 must serialise like DIV=1.
    bus_write(4'h8, 32'd0, 4'h3, 1'b1);
    exp_bytes[0] = 8'hC3;
    fork
      push_bytes(1);
      rx_frames(1, 1);
    join

    // Random rounds: random divisor and a random burst of bytes.
    for (int round = 0; round < 6; round++) begin
      div = $urandom_range(1, 6);
      n   = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) exp_bytes[i] = 8'($urandom);
      bus_write(4'h8, 32'(div), 4'h3, 1'b1);
      fork
        push_bytes(n);
        rx_frames(div, n);
      join
      bus_read(4'h4, 1'b1, 1'b1, rdata);
      check("rand_status", rdata, 32'h0000_0002);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
